// File: rtl/servo_pkg.sv
// Shared constants, cycle-count helpers and the channel FSM state type for the
// servo PWM decoder.
package servo_pkg;

    localparam int DUTY_W = 8;
    localparam logic [DUTY_W-1:0] DUTY_MAX = '1;

    typedef enum logic [1:0] {
        WAIT_LOW,
        IDLE,
        MEAS_MIN,
        MEAS_SCALE
    } chan_state_t;

    function automatic int unsigned us_to_cycles(input int unsigned us, input int unsigned clk_freq);
        return us * (clk_freq / 1000000);
    endfunction

    // Cycles per duty code step, truncated; never allowed to collapse to zero.
    function automatic int unsigned step_cycles(input int unsigned min_us, input int unsigned max_us,
                                                input int unsigned clk_freq);
        int unsigned s;
        s = ((max_us - min_us) * (clk_freq / 1000000)) / 256;
        return (s == 0) ? 1 : s;
    endfunction

    function automatic int cnt_width(input int unsigned a, input int unsigned b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/servo_pwm_decoder_if.sv
// Pulse inputs and addressed readback bundle of the servo PWM decoder.
interface servo_pwm_decoder_if
    import servo_pkg::*;
#(
    parameter int unsigned N_CHANNELS = 4,
    parameter int unsigned ADDR_W     = 2
);
    logic [N_CHANNELS-1:0] pwm_in;
    logic [ADDR_W-1:0]     address;
    logic [DUTY_W-1:0]     duty_cycle_value;
    logic                  sample_valid;
    logic [N_CHANNELS-1:0] new_sample;
    logic [N_CHANNELS-1:0] pulse_error;

    modport slave (
        input  pwm_in,
        input  address,
        output duty_cycle_value,
        output sample_valid,
        output new_sample,
        output pulse_error
    );

    modport master (
        output pwm_in,
        output address,
        input  duty_cycle_value,
        input  sample_valid,
        input  new_sample,
        input  pulse_error
    );
endinterface

// File: rtl/pulse_width_capture.sv
// One servo channel: input synchronizer, pulse-width measuring FSM that turns the
// high time into an 8-bit duty code, sticky error flag and frame watchdog.
module pulse_width_capture
    import servo_pkg::*;
#(
    parameter int unsigned CLK_FREQ         = 50000000,
    parameter int unsigned MIN_PULSE_US     = 1000,
    parameter int unsigned MAX_PULSE_US     = 2000,
    parameter int unsigned HIGH_TIMEOUT_US  = 3000,
    parameter int unsigned FRAME_TIMEOUT_US = 25000
)
(
    input  logic              clock,
    input  logic              reset,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] code,
    output logic              valid,
    output logic              new_sample,
    output logic              pulse_error
);
    localparam int unsigned MIN_CYC      = us_to_cycles(MIN_PULSE_US, CLK_FREQ);
    localparam int unsigned STEP_CYC     = step_cycles(MIN_PULSE_US, MAX_PULSE_US, CLK_FREQ);
    localparam int unsigned HIGH_TO_CYC  = us_to_cycles(HIGH_TIMEOUT_US, CLK_FREQ);
    localparam int unsigned FRAME_TO_CYC = us_to_cycles(FRAME_TIMEOUT_US, CLK_FREQ);
    localparam int CNT_W = cnt_width(FRAME_TO_CYC, HIGH_TO_CYC);

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_CYC);
    localparam logic [CNT_W-1:0] STEP_END = CNT_W'(STEP_CYC - 1);
    localparam logic [CNT_W-1:0] HIGH_C   = CNT_W'(HIGH_TO_CYC);
    localparam logic [CNT_W-1:0] FRAME_C  = CNT_W'(FRAME_TO_CYC);

    // Synchronizer resets high so a line already high at reset release never
    // produces a rising edge; WAIT_LOW then drops the rest of that pulse.
    logic [2:0]        sync_reg;
    logic              rise_reg, fall_reg;
    logic              level;

    chan_state_t       state_reg, state_next;
    logic [CNT_W-1:0]  hi_cnt_reg, hi_cnt_next, hi_inc;
    logic [CNT_W-1:0]  step_cnt_reg, step_cnt_next;
    logic [CNT_W-1:0]  frame_cnt_reg, frame_cnt_next, frame_inc;
    logic [DUTY_W-1:0] acc_reg, acc_next;
    logic [DUTY_W-1:0] code_reg, code_next;
    logic              valid_reg, valid_next;
    logic              new_sample_reg, new_sample_next;
    logic              error_reg, error_next;

    assign level     = sync_reg[2];
    assign hi_inc    = hi_cnt_reg + ONE;
    assign frame_inc = frame_cnt_reg + ONE;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_reg       <= '1;
            rise_reg       <= 1'b0;
            fall_reg       <= 1'b0;
            state_reg      <= WAIT_LOW;
            hi_cnt_reg     <= '0;
            step_cnt_reg   <= '0;
            frame_cnt_reg  <= '0;
            acc_reg        <= '0;
            code_reg       <= '0;
            valid_reg      <= 1'b0;
            new_sample_reg <= 1'b0;
            error_reg      <= 1'b0;
        end else begin
            sync_reg       <= {sync_reg[1:0], pwm_in};
            rise_reg       <= sync_reg[1] & ~sync_reg[2];
            fall_reg       <= ~sync_reg[1] & sync_reg[2];
            state_reg      <= state_next;
            hi_cnt_reg     <= hi_cnt_next;
            step_cnt_reg   <= step_cnt_next;
            frame_cnt_reg  <= frame_cnt_next;
            acc_reg        <= acc_next;
            code_reg       <= code_next;
            valid_reg      <= valid_next;
            new_sample_reg <= new_sample_next;
            error_reg      <= error_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        hi_cnt_next     = hi_cnt_reg;
        step_cnt_next   = step_cnt_reg;
        frame_cnt_next  = frame_cnt_reg;
        acc_next        = acc_reg;
        code_next       = code_reg;
        valid_next      = valid_reg;
        new_sample_next = 1'b0;
        error_next      = error_reg;

        // A rising edge restarts the frame watchdog, taking priority over expiry.
        if (rise_reg) begin
            frame_cnt_next = '0;
        end else if (frame_cnt_reg != FRAME_C) begin
            frame_cnt_next = frame_inc;
            if (frame_inc == FRAME_C)
                valid_next = 1'b0;
        end

        case (state_reg)
            WAIT_LOW: begin
                if (!level)
                    state_next = IDLE;
            end
            IDLE: begin
                if (rise_reg) begin
                    hi_cnt_next   = ONE;
                    step_cnt_next = '0;
                    acc_next      = '0;
                    state_next    = MEAS_MIN;
                end
            end
            MEAS_MIN, MEAS_SCALE: begin
                if (fall_reg) begin
                    code_next       = (state_reg == MEAS_MIN) ? '0 : acc_reg;
                    valid_next      = 1'b1;
                    new_sample_next = 1'b1;
                    error_next      = 1'b0;
                    state_next      = IDLE;
                end else if (hi_inc == HIGH_C) begin
                    error_next = 1'b1;
                    state_next = WAIT_LOW;
                end else begin
                    hi_cnt_next = hi_inc;
                    if (state_reg == MEAS_MIN) begin
                        if (hi_inc == MIN_C) begin
                            step_cnt_next = '0;
                            state_next    = MEAS_SCALE;
                        end
                    end else if (step_cnt_reg == STEP_END) begin
                        step_cnt_next = '0;
                        if (acc_reg != DUTY_MAX)
                            acc_next = acc_reg + 1'b1;
                    end else begin
                        step_cnt_next = step_cnt_reg + ONE;
                    end
                end
            end
            default: state_next = WAIT_LOW;
        endcase
    end

    assign code        = code_reg;
    assign valid       = valid_reg;
    assign new_sample  = new_sample_reg;
    assign pulse_error = error_reg;

endmodule

// File: rtl/servo_pwm_decoder.sv
// Multi-channel servo pulse-width decoder: one capture block per channel plus a
// registered, addressed readback of code and valid.
module servo_pwm_decoder
    import servo_pkg::*;
#(
    parameter int unsigned CLK_FREQ         = 50000000,
    parameter int unsigned N_CHANNELS       = 4,
    parameter int unsigned ADDR_W           = 2,
    parameter int unsigned MIN_PULSE_US     = 1000,
    parameter int unsigned MAX_PULSE_US     = 2000,
    parameter int unsigned HIGH_TIMEOUT_US  = 3000,
    parameter int unsigned FRAME_TIMEOUT_US = 25000
)
(
    input logic                clock,
    input logic                reset,
    servo_pwm_decoder_if.slave bus
);
    localparam int unsigned N_SLOTS = 1 << ADDR_W;

    // Address slots beyond the last channel read back as code 0, not valid.
    logic [DUTY_W-1:0]     code_slot [N_SLOTS];
    logic [N_SLOTS-1:0]    valid_slot;
    logic [N_CHANNELS-1:0] new_sample_w;
    logic [N_CHANNELS-1:0] pulse_error_w;
    logic [DUTY_W-1:0]     duty_reg;
    logic                  sample_valid_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_SLOTS; gi++) begin : g_slot
            if (gi < N_CHANNELS) begin : g_chan
                pulse_width_capture #(
                    .CLK_FREQ         (CLK_FREQ),
                    .MIN_PULSE_US     (MIN_PULSE_US),
                    .MAX_PULSE_US     (MAX_PULSE_US),
                    .HIGH_TIMEOUT_US  (HIGH_TIMEOUT_US),
                    .FRAME_TIMEOUT_US (FRAME_TIMEOUT_US)
                ) u_capture (
                    .clock       (clock),
                    .reset       (reset),
                    .pwm_in      (bus.pwm_in[gi]),
                    .code        (code_slot[gi]),
                    .valid       (valid_slot[gi]),
                    .new_sample  (new_sample_w[gi]),
                    .pulse_error (pulse_error_w[gi])
                );
            end else begin : g_empty
                assign code_slot[gi]  = '0;
                assign valid_slot[gi] = 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            duty_reg         <= '0;
            sample_valid_reg <= 1'b0;
        end else begin
            duty_reg         <= code_slot[bus.address];
            sample_valid_reg <= valid_slot[bus.address];
        end
    end

    assign bus.duty_cycle_value = duty_reg;
    assign bus.sample_valid     = sample_valid_reg;
    assign bus.new_sample       = new_sample_w;
    assign bus.pulse_error      = pulse_error_w;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Directed bench for servo_pwm_decoder at a 1 MHz clock (1 cycle per microsecond)
// with scaled pulse limits; a scoreboard matches every new_sample strobe.
module tb_servo_pwm_decoder;
    localparam int MIN_US   = 100;
    localparam int MAX_US   = 612;
    localparam int HIGH_US  = 700;
    localparam int FRAME_US = 1500;
    localparam int STEP     = (MAX_US - MIN_US) / 256;
    localparam int PERIOD   = 1000;

    typedef struct {
        int ch;
        int code;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] pwm = '0;
    logic [1:0] addr = '0;

    sb_t sb[$];
    int  checks = 0;
    int  failures = 0;
    int  strobe_cnt [4] = '{0, 0, 0, 0};
    int  exp_code [4] = '{0, 0, 0, 0};
    bit  pend = 1'b0;
    int  pend_code = 0;
    int  base;

    servo_pwm_decoder_if #(.N_CHANNELS(4), .ADDR_W(2)) bus ();

    assign bus.pwm_in  = pwm;
    assign bus.address = addr;

    servo_pwm_decoder #(
        .CLK_FREQ         (1000000),
        .N_CHANNELS       (4),
        .ADDR_W           (2),
        .MIN_PULSE_US     (MIN_US),
        .MAX_PULSE_US     (MAX_US),
        .HIGH_TIMEOUT_US  (HIGH_US),
        .FRAME_TIMEOUT_US (FRAME_US)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic int model_code(input int w);
        int c;
        if (w < MIN_US) return 0;
        c = (w - MIN_US) / STEP;
        return (c > 255) ? 255 : c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // One frame: each channel high for w[ch] cycles from the frame start (0 = idle).
    task automatic run_frame(input int w0, input int w1, input int w2, input int w3);
        int w [4];
        w = '{w0, w1, w2, w3};
        for (int ch = 0; ch < 4; ch++) begin
            if (w[ch] > 0 && w[ch] < HIGH_US) begin
                sb.push_back('{ch, model_code(w[ch])});
                exp_code[ch] = model_code(w[ch]);
            end
        end
        for (int c = 0; c < PERIOD; c++) begin
            for (int ch = 0; ch < 4; ch++) pwm[ch] = (c < w[ch]);
            @(negedge clk);
        end
        pwm = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_duty"}, bus.duty_cycle_value, 0);
        check({tag, "_valid"}, bus.sample_valid, 0);
        check({tag, "_new_sample"}, bus.new_sample, 0);
        check({tag, "_pulse_error"}, bus.pulse_error, 0);
    endtask

    // Scoreboard monitor: every strobe must match a queued pulse; the addressed
    // channel's code is checked on the readback one clock later.
    always @(negedge clk) begin
        if (pend) begin
            check("readback_code", bus.duty_cycle_value, pend_code);
            check("readback_valid", bus.sample_valid, 1);
            pend = 1'b0;
        end
        if (!rst) begin
            for (int ch = 0; ch < 4; ch++) begin
                if (bus.new_sample[ch]) begin
                    int idx;
                    idx = -1;
                    strobe_cnt[ch]++;
                    for (int k = 0; k < sb.size(); k++) begin
                        if (idx < 0 && sb[k].ch == ch) idx = k;
                    end
                    check("strobe_expected", idx >= 0, 1);
                    if (idx >= 0) begin
                        $display("strobe ch=%0d expected_code=%0d t=%0t", ch, sb[idx].code, $time);
                        if (ch == int'(addr)) begin
                            pend      = 1'b1;
                            pend_code = sb[idx].code;
                        end
                        sb.delete(idx);
                    end
                end
            end
        end
    end

    initial begin
        // Reset state
        wait_cycles(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        wait_cycles(10);

        // ch0 mid-scale pulse, three frames
        addr = 2'd0;
        base = strobe_cnt[0];
        for (int f = 0; f < 3; f++) run_frame(356, 0, 0, 0);
        check("ch0_strobes_per_frame", strobe_cnt[0] - base, 3);
        check("ch0_code", bus.duty_cycle_value, 128);
        check("ch0_valid", bus.sample_valid, 1);

        // ch1 at and below the minimum width
        addr = 2'd1;
        run_frame(0, 100, 0, 0);
        run_frame(0, 90, 0, 0);
        check("ch1_code_min", bus.duty_cycle_value, 0);
        check("ch1_strobes", strobe_cnt[1], 2);

        // ch2 full scale saturates
        addr = 2'd2;
        run_frame(0, 0, 612, 0);
        check("ch2_code_sat", bus.duty_cycle_value, 255);

        // ch3 good, then timed out, then good again
        addr = 2'd3;
        run_frame(0, 0, 0, 202);
        check("ch3_code", bus.duty_cycle_value, 51);
        base = strobe_cnt[3];
        run_frame(0, 0, 0, 750);
        check("ch3_error_set", bus.pulse_error[3], 1);
        check("ch3_code_held", bus.duty_cycle_value, 51);
        check("ch3_no_strobe_on_error", strobe_cnt[3] - base, 0);
        run_frame(0, 0, 0, 202);
        check("ch3_error_cleared", bus.pulse_error[3], 0);
        check("ch3_strobe_after_error", strobe_cnt[3] - base, 1);

        // Frame timeout on ch0
        addr = 2'd0;
        run_frame(356, 0, 0, 0);
        run_frame(356, 0, 0, 0);
        wait_cycles(400);
        check("frame_valid_before_timeout", bus.sample_valid, 1);
        wait_cycles(200);
        check("frame_valid_after_timeout", bus.sample_valid, 0);
        check("frame_code_held", bus.duty_cycle_value, 128);

        // Reset in the middle of a ch0 pulse
        base = strobe_cnt[0];
        pwm[0] = 1'b1;
        wait_cycles(50);
        rst = 1'b1;
        wait_cycles(2);
        check_reset_outputs("midpulse_reset");
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(150);
        pwm[0] = 1'b0;
        wait_cycles(20);
        check("partial_pulse_ignored", strobe_cnt[0] - base, 0);
        check("partial_valid", bus.sample_valid, 0);
        check("partial_code", bus.duty_cycle_value, 0);
        run_frame(300, 0, 0, 0);
        check("post_reset_code", bus.duty_cycle_value, 100);
        check("post_reset_strobe", strobe_cnt[0] - base, 1);

        // All channels concurrently, then an address sweep
        run_frame(300, 160, 500, 236);
        run_frame(300, 160, 500, 236);
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a);
            @(negedge clk);
            $display("readback addr=%0d duty=%0d valid=%0d", a, bus.duty_cycle_value, bus.sample_valid);
            check($sformatf("sweep_code_%0d", a), bus.duty_cycle_value, exp_code[a]);
            check($sformatf("sweep_valid_%0d", a), bus.sample_valid, 1);
        end
        check("pulse_error_all_clear", bus.pulse_error, 0);

        wait_cycles(10);
        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
